// File: rtl/adc_iq_frame_packer_if.sv
// ----------------------------------------------------------------------------
// adc_iq_frame_packer_if
// Output word stream of the I/Q frame packer.
//   m_valid : word available (producer -> consumer)
//   m_ready : consumer accepts word (consumer -> producer)
//   m_data  : {Q, I} sample pair
//   m_chan  : channel index of the word
//   m_last  : word is the last of its frame
// ----------------------------------------------------------------------------
interface adc_iq_frame_packer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                    m_valid;
    logic                    m_ready;
    logic [2*DATA_WIDTH-1:0] m_data;
    logic [1:0]              m_chan;
    logic                    m_last;

    modport master (output m_valid, m_data, m_chan, m_last, input m_ready);
    modport slave  (input  m_valid, m_data, m_chan, m_last, output m_ready);
endinterface

// File: rtl/adc_iq_frame_packer.sv
// ----------------------------------------------------------------------------
// adc_iq_frame_packer
// Pairs per-channel I and Q ADC samples, assembles one frame across all
// enabled channels and queues the frame words in a first-word-fall-through
// FIFO that drains over a valid/ready stream.
//   l_clk, l_aresetn          : clock, asynchronous active-low reset
//   adc_enable_i/q            : per-channel enables (channel on = both set)
//   adc_valid_i/q, adc_data_i/q : per-channel sample strobes and data
//   m (master)                : output word stream {Q,I}, chan, last
//   fifo_level                : words held in the FIFO
//   frame_cnt                 : frames accepted into the FIFO (wraps)
//   ovf                       : sticky, a frame was dropped for lack of space
//   align_err                 : sticky, I or Q overwritten before pairing
//   flag_clr                  : clears ovf and align_err
// ----------------------------------------------------------------------------
module adc_iq_frame_packer #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         l_clk,
    input  logic                         l_aresetn,
    input  logic [NUM_CH-1:0]            adc_enable_i,
    input  logic [NUM_CH-1:0]            adc_valid_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] adc_data_i,
    input  logic [NUM_CH-1:0]            adc_enable_q,
    input  logic [NUM_CH-1:0]            adc_valid_q,
    input  logic [NUM_CH*DATA_WIDTH-1:0] adc_data_q,
    adc_iq_frame_packer_if.master        m,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [31:0]                  frame_cnt,
    output logic                         ovf,
    output logic                         align_err,
    input  logic                         flag_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = 2 * DATA_WIDTH;   // {Q, I}
    localparam int WW = SW + 3;           // {chan[1:0], last, {Q, I}}

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t                r_state, w_state_nxt;

    // pair slots
    logic [DATA_WIDTH-1:0] r_slot_i [NUM_CH];
    logic [DATA_WIDTH-1:0] r_slot_q [NUM_CH];
    logic [NUM_CH-1:0]     r_i_have, r_q_have;
    logic [NUM_CH-1:0]     w_i_have_nxt, w_q_have_nxt;
    logic [NUM_CH-1:0]     w_base_i, w_base_q;
    logic [NUM_CH-1:0]     w_ld_i, w_ld_q;
    logic                  w_align_hit;

    // frame snapshot and channels still to be written
    logic [SW-1:0]         r_buf [NUM_CH];
    logic [NUM_CH-1:0]     r_rem, w_rem_nxt;
    logic                  w_found;

    // FIFO
    logic [WW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [WW-1:0]         w_head, w_push_word;
    logic                  w_push, w_pop, w_valid;

    logic [31:0]           r_frame_cnt;
    logic                  r_ovf, r_align;

    logic [NUM_CH-1:0]     w_en;
    logic [LW-1:0]         w_k, w_free;
    logic                  w_all_done, w_frame_ready, w_launch, w_drop;

    assign w_en = adc_enable_i & adc_enable_q;

    // K and "every enabled slot complete"
    always_comb begin
        w_k        = '0;
        w_all_done = 1'b1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_en[c]) begin
                w_k = w_k + LW'(1);
                if (!(r_i_have[c] && r_q_have[c])) w_all_done = 1'b0;
            end
        end
    end

    assign w_free        = LW'(FIFO_DEPTH) - r_level;
    assign w_frame_ready = (r_state == S_IDLE) && (w_k != '0) && w_all_done;
    assign w_launch      = w_frame_ready && (w_free >= w_k);
    assign w_drop        = w_frame_ready && (w_free < w_k);

    // Slot update. On launch/drop the enabled slots are cleared first, so a
    // sample strobed on that same edge starts the next frame. A complete slot
    // waiting for IDLE holds its pair and ignores further samples.
    always_comb begin
        w_i_have_nxt = '0;
        w_q_have_nxt = '0;
        w_base_i     = '0;
        w_base_q     = '0;
        w_ld_i       = '0;
        w_ld_q       = '0;
        w_align_hit  = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_en[c]) begin
                w_base_i[c]     = r_i_have[c] & ~w_frame_ready;
                w_base_q[c]     = r_q_have[c] & ~w_frame_ready;
                w_i_have_nxt[c] = w_base_i[c];
                w_q_have_nxt[c] = w_base_q[c];
                if (!(w_base_i[c] && w_base_q[c])) begin
                    if (adc_valid_i[c]) begin
                        w_ld_i[c]       = 1'b1;
                        w_i_have_nxt[c] = 1'b1;
                        if (w_base_i[c]) w_align_hit = 1'b1;
                    end
                    if (adc_valid_q[c]) begin
                        w_ld_q[c]       = 1'b1;
                        w_q_have_nxt[c] = 1'b1;
                        if (w_base_q[c]) w_align_hit = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge l_clk or negedge l_aresetn) begin
        if (!l_aresetn) begin
            r_i_have <= '0;
            r_q_have <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_slot_i[c] <= '0;
                r_slot_q[c] <= '0;
            end
        end else begin
            r_i_have <= w_i_have_nxt;
            r_q_have <= w_q_have_nxt;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (w_ld_i[c]) r_slot_i[c] <= adc_data_i[c*DATA_WIDTH +: DATA_WIDTH];
                if (w_ld_q[c]) r_slot_q[c] <= adc_data_q[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM next state: WRITE emits the lowest remaining channel each cycle
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_rem_nxt   = r_rem;
        w_push_word = '0;
        w_found     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_push = 1'b1;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (r_rem[c] && !w_found) begin
                        w_found                 = 1'b1;
                        w_rem_nxt[c]            = 1'b0;
                        w_push_word[SW-1:0]     = r_buf[c];
                        w_push_word[WW-1 -: 2]  = 2'(c);
                    end
                end
                w_push_word[SW] = (w_rem_nxt == '0);
                if (w_rem_nxt == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge l_clk or negedge l_aresetn) begin
        if (!l_aresetn) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_frame_cnt <= '0;
            r_ovf       <= 1'b0;
            r_align     <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) r_buf[c] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_rem       <= w_en;
                r_frame_cnt <= r_frame_cnt + 32'd1;
                for (int unsigned c = 0; c < NUM_CH; c++) r_buf[c] <= {r_slot_q[c], r_slot_i[c]};
            end else if (r_state == S_WRITE) begin
                r_rem <= w_rem_nxt;
            end
            // a set event in the same cycle as flag_clr wins
            r_ovf   <= w_drop      | (r_ovf   & ~flag_clr);
            r_align <= w_align_hit | (r_align & ~flag_clr);
        end
    end

    // FIFO storage (not reset; outputs are gated by m_valid)
    always_ff @(posedge l_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_word;
    end

    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & m.m_ready;

    always_ff @(posedge l_clk or negedge l_aresetn) begin
        if (!l_aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign m.m_valid = w_valid;
    assign m.m_data  = w_valid ? w_head[SW-1:0]  : '0;
    assign m.m_last  = w_valid ? w_head[SW]      : 1'b0;
    assign m.m_chan  = w_valid ? w_head[WW-1 -: 2] : 2'b00;

    assign fifo_level = r_level;
    assign frame_cnt  = r_frame_cnt;
    assign ovf        = r_ovf;
    assign align_err  = r_align;

endmodule

// File: tb/tb_adc_iq_frame_packer.sv
module tb_adc_iq_frame_packer;
    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int DEPTH  = 4;

    logic        l_clk = 1'b0;
    logic        l_aresetn = 1'b0;
    logic [3:0]  adc_enable_i = '0, adc_enable_q = '0;
    logic [3:0]  adc_valid_i = '0, adc_valid_q = '0;
    logic [63:0] adc_data_i = '0, adc_data_q = '0;
    logic [2:0]  fifo_level;
    logic [31:0] frame_cnt;
    logic        ovf, align_err;
    logic        flag_clr = 1'b0;

    always #5 l_clk = ~l_clk;

    adc_iq_frame_packer_if #(.DATA_WIDTH(DW)) u_if ();

    adc_iq_frame_packer #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .l_clk        (l_clk),
        .l_aresetn    (l_aresetn),
        .adc_enable_i (adc_enable_i),
        .adc_valid_i  (adc_valid_i),
        .adc_data_i   (adc_data_i),
        .adc_enable_q (adc_enable_q),
        .adc_valid_q  (adc_valid_q),
        .adc_data_q   (adc_data_q),
        .m            (u_if),
        .fifo_level   (fifo_level),
        .frame_cnt    (frame_cnt),
        .ovf          (ovf),
        .align_err    (align_err),
        .flag_clr     (flag_clr)
    );

    typedef struct packed {
        logic [1:0]  chan;
        logic        last;
        logic [31:0] data;
    } word_t;

    // reference model: expected words, occupancy, counters, sticky flags
    word_t exp_q[$];
    int    pushed = 0, popped = 0;
    int    fc_m = 0;
    bit    ovf_m = 0, align_m = 0;

    int    n_checks = 0, n_pass = 0;
    int    ready_mode = 0;   // 0 low, 1 high, 2 toggle, 3 random

    // per-frame schedule: sample times and values per channel
    int          ti[4], tq[4];
    logic [15:0] vi[4], vq[4];
    int          dup_ch = -1, dup_t = 0;
    logic [15:0] dup_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge l_clk);
        #1;
        adc_valid_i = '0;
        adc_valid_q = '0;
    endtask

    initial begin
        u_if.m_ready = 1'b0;
        forever begin
            @(posedge l_clk);
            #1;
            case (ready_mode)
                0: u_if.m_ready = 1'b0;
                1: u_if.m_ready = 1'b1;
                2: u_if.m_ready = ~u_if.m_ready;
                default: u_if.m_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // compare every visible word against the head of the expected queue
    always @(negedge l_clk) begin
        if (l_aresetn && u_if.m_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word",
                         {u_if.m_chan, u_if.m_last, u_if.m_data});
            end else begin
                check("word", 64'({u_if.m_chan, u_if.m_last, u_if.m_data}), 64'(exp_q[0]));
                if (u_if.m_ready) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
    end

    task automatic check_status();
        check("frame_cnt", 64'(frame_cnt), 64'(fc_m));
        check("ovf", 64'(ovf), 64'(ovf_m));
        check("align_err", 64'(align_err), 64'(align_m));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_valid"}, 64'(u_if.m_valid), 64'd0);
        check({tag, "_m_data"}, 64'(u_if.m_data), 64'd0);
        check({tag, "_m_chan"}, 64'(u_if.m_chan), 64'd0);
        check({tag, "_m_last"}, 64'(u_if.m_last), 64'd0);
        check({tag, "_fifo_level"}, 64'(fifo_level), 64'd0);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        check({tag, "_ovf"}, 64'(ovf), 64'd0);
        check({tag, "_align_err"}, 64'(align_err), 64'd0);
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            step();
            g++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: got %0d words outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_valid(input string name);
        int g = 0;
        @(negedge l_clk);
        while (!u_if.m_valid && g < 50) begin
            @(negedge l_clk);
            g++;
        end
        if (!u_if.m_valid) begin
            n_checks++;
            $display("FAIL %s: got no m_valid, expected a word within 50 cycles", name);
        end
    endtask

    task automatic rand_sched(input logic [3:0] mask, input bit allow_dup);
        int c;
        for (int i = 0; i < 4; i++) begin
            ti[i] = $urandom_range(0, 3);
            tq[i] = $urandom_range(0, 3);
            vi[i] = 16'($urandom);
            vq[i] = 16'($urandom);
        end
        dup_ch = -1;
        if (allow_dup && $urandom_range(0, 4) == 0) begin
            do c = $urandom_range(0, 3); while (!mask[c]);
            dup_ch  = c;
            dup_t   = 0;
            dup_val = 16'($urandom);
            ti[c]   = $urandom_range(1, 2);
            tq[c]   = ti[c] + $urandom_range(0, 1);
        end
    endtask

    // Drive one frame's samples, then record what the frame must produce.
    task automatic run_frame(input logic [3:0] mask, input bit wait_room, input bit post_wait);
        int k = 0, hi = 0, maxt = 0, g = 0;
        word_t w;
        for (int c = 0; c < 4; c++) if (mask[c]) begin
            k++;
            hi = c;
            if (ti[c] > maxt) maxt = ti[c];
            if (tq[c] > maxt) maxt = tq[c];
        end
        if (wait_room) begin
            while ((pushed - popped) + k > DEPTH && g < 500) begin
                step();
                g++;
            end
            if ((pushed - popped) + k > DEPTH) begin
                n_checks++;
                $display("FAIL room_timeout: got %0d words held, expected room for %0d", pushed - popped, k);
            end
        end
        adc_enable_q = mask;
        adc_enable_i = mask | (4'($urandom) & ~mask);
        for (int t = 0; t <= maxt; t++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[c]) begin
                    if (dup_ch == c && dup_t == t) begin
                        adc_valid_i[c] = 1'b1;
                        adc_data_i[c*16 +: 16] = dup_val;
                    end
                    if (ti[c] == t) begin
                        adc_valid_i[c] = 1'b1;
                        adc_data_i[c*16 +: 16] = vi[c];
                    end
                    if (tq[c] == t) begin
                        adc_valid_q[c] = 1'b1;
                        adc_data_q[c*16 +: 16] = vq[c];
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    adc_valid_i[c] = 1'b1;
                    adc_valid_q[c] = 1'b1;
                    adc_data_i[c*16 +: 16] = 16'($urandom);
                    adc_data_q[c*16 +: 16] = 16'($urandom);
                end
            end
            step();
        end
        if ((pushed - popped) + k <= DEPTH) begin
            for (int c = 0; c < 4; c++) if (mask[c]) begin
                w.chan = 2'(c);
                w.last = (c == hi);
                w.data = {vq[c], vi[c]};
                exp_q.push_back(w);
            end
            pushed += k;
            fc_m++;
        end else begin
            ovf_m = 1'b1;
        end
        if (dup_ch >= 0) align_m = 1'b1;
        if (post_wait) repeat (k + 2) step();
    endtask

    initial begin
        logic [3:0] mk;
        int p0;

        // reset state
        #12;
        check_all_zero("reset");
        @(negedge l_clk);
        l_aresetn = 1'b1;
        step();

        // two channels, ch0 pair then ch1 pair one cycle later
        ready_mode = 1;
        step();
        ti[0] = 0; tq[0] = 0; vi[0] = 16'h1111; vq[0] = 16'h2222;
        ti[1] = 1; tq[1] = 1; vi[1] = 16'h3333; vq[1] = 16'h4444;
        dup_ch = -1;
        run_frame(4'b0011, 1'b1, 1'b0);
        @(negedge l_clk);
        check("lat_e0_valid", 64'(u_if.m_valid), 64'd0);
        @(negedge l_clk);
        check("lat_e1_valid", 64'(u_if.m_valid), 64'd0);
        @(negedge l_clk);
        check("lat_e2_valid", 64'(u_if.m_valid), 64'd1);
        check("first_word", 64'({u_if.m_chan, u_if.m_last, u_if.m_data}), 64'({2'd0, 1'b0, 32'h2222_1111}));
        @(negedge l_clk);
        check("second_word", 64'({u_if.m_chan, u_if.m_last, u_if.m_data}), 64'({2'd1, 1'b1, 32'h4444_3333}));
        repeat (3) step();
        check("frame_cnt_one", 64'(frame_cnt), 64'd1);
        check_status();

        // I overwritten before its Q arrives
        ti[0] = 1; tq[0] = 2; vi[0] = 16'hBBBB; vq[0] = 16'hCCCC;
        dup_ch = 0; dup_t = 0; dup_val = 16'hAAAA;
        run_frame(4'b0001, 1'b1, 1'b0);
        wait_valid("align_wait");
        check("align_word", 64'(u_if.m_data), 64'h0000_0000_CCCC_BBBB);
        check("align_set", 64'(align_err), 64'd1);
        repeat (3) step();
        check_status();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        align_m = 1'b0;
        check("align_clr", 64'(align_err), 64'd0);

        // FIFO full: two frames stored, third dropped
        wait_drain("pre_ovf_drain");
        ready_mode = 0;
        repeat (2) step();
        repeat (3) begin
            rand_sched(4'b0011, 1'b0);
            run_frame(4'b0011, 1'b0, 1'b1);
        end
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_set", 64'(ovf), 64'd1);
        check("ovf_frame_cnt", 64'(frame_cnt), 64'd4);
        check_status();
        p0 = popped;
        ready_mode = 1;
        wait_drain("ovf_drain");
        repeat (4) step();
        check("drain_count", 64'(popped - p0), 64'd4);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        ovf_m = 1'b0;
        check("ovf_clr", 64'(ovf), 64'd0);

        // only ch1 enabled; noise on the other channels
        ti[1] = 0; tq[1] = 1; vi[1] = 16'h5555; vq[1] = 16'h6666;
        dup_ch = -1;
        run_frame(4'b0010, 1'b1, 1'b0);
        wait_valid("ch1_wait");
        check("ch1_word", 64'({u_if.m_chan, u_if.m_last, u_if.m_data}), 64'({2'd1, 1'b1, 32'h6666_5555}));
        repeat (3) step();
        repeat (4) begin
            rand_sched(4'b0010, 1'b0);
            run_frame(4'b0010, 1'b1, 1'b1);
            check_status();
        end

        // random frames with stalling consumer
        for (int n = 0; n < 30; n++) begin
            ready_mode = (n < 15) ? 2 : 3;
            mk = 4'($urandom_range(1, 15));
            rand_sched(mk, 1'b1);
            run_frame(mk, 1'b1, 1'b1);
            check_status();
        end
        ready_mode = 1;
        wait_drain("random_drain");

        // reset in the middle of WRITE
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        align_m = 1'b0;
        ovf_m = 1'b0;
        ti[0] = 0; tq[0] = 0; ti[1] = 0; tq[1] = 0;
        vi[0] = 16'h0101; vq[0] = 16'h0202; vi[1] = 16'h0303; vq[1] = 16'h0404;
        dup_ch = -1;
        run_frame(4'b0011, 1'b1, 1'b0);
        @(posedge l_clk);
        @(posedge l_clk);
        #2;
        l_aresetn = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        pushed = 0; popped = 0; fc_m = 0; ovf_m = 1'b0; align_m = 1'b0;
        repeat (2) @(negedge l_clk);
        l_aresetn = 1'b1;
        step();
        rand_sched(4'b0011, 1'b0);
        run_frame(4'b0011, 1'b1, 1'b1);
        check("post_reset_frame_cnt", 64'(frame_cnt), 64'd1);
        wait_drain("final_drain");
        check_status();
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
